// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiplier: operator encoding, FSM states, signedness helpers.
package ibex_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL,
    MUL_OP_MULH,
    MUL_OP_MULHSU,
    MUL_OP_MULHU
  } mul_iter_op_e;

  typedef enum logic [2:0] {
    MUL_IDLE,
    MUL_PREP,
    MUL_ISSUE,
    MUL_WAIT,
    MUL_FINISH,
    MUL_DONE
  } mul_iter_state_e;

  function automatic logic op_signed_a(input mul_iter_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_signed_b(input mul_iter_op_e op);
    return op == MUL_OP_MULH;
  endfunction

endpackage

// File: rtl/ibex_mul_iter_signfix.sv
// Combinational sign handling: operand magnitudes and product sign for PREP, conditional
// 64-bit two's complement of the unsigned product for FINISH. Zero latency, no handshake.
module ibex_mul_iter_signfix
  import ibex_pkg::*;
(
  input  logic [31:0]  operand_a,
  input  logic [31:0]  operand_b,
  input  mul_iter_op_e operator,
  input  logic [63:0]  prod,
  input  logic         neg,
  output logic [31:0]  a_mag,
  output logic [31:0]  b_mag,
  output logic         sign_diff,
  output logic [63:0]  prod_fixed
);

  logic sign_a;
  logic sign_b;

  assign sign_a = op_signed_a(operator) & operand_a[31];
  assign sign_b = op_signed_b(operator) & operand_b[31];

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag      = sign_a ? (~operand_a + 32'd1) : operand_a;
  assign b_mag      = sign_b ? (~operand_b + 32'd1) : operand_b;
  assign sign_diff  = sign_a ^ sign_b;
  assign prod_fixed = neg ? (~prod + 64'd1) : prod;

endmodule

// File: rtl/ibex_mul_iter.sv
// Iterative RV32M multiplier on the shared registered adder: 67 cycles accept-to-valid with constant grant, +1 per denied grant;
// stalls in ISSUE without grant, holds the result in DONE until mul_ready_i. Option IBEX_MUL_ITER_EARLY_EXIT_EN stops once multiplier bits run out.
module ibex_mul_iter
  import ibex_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mul_valid_i,
  output logic         mul_ready_o,
  input  mul_iter_op_e mul_operator_i,
  input  logic [31:0]  mul_operand_a_i,
  input  logic [31:0]  mul_operand_b_i,
  input  logic         mul_kill_i,
  output logic         adder_req_o,
  input  logic         adder_gnt_i,
  output logic [31:0]  b_mul_alu_operand_a_o,
  output logic [31:0]  b_mul_alu_operand_b_o,
  input  logic [31:0]  b_mul_alu_adder_result_i,
  output logic [31:0]  mul_result_o,
  output logic         mul_valid_o,
  input  logic         mul_ready_i
);

  mul_iter_state_e state;
  mul_iter_op_e    op_q;
  logic [31:0]     a_q, b_q, a_mag_q, acc_hi, acc_lo;
  logic            neg_q;
  logic [5:0]      cnt;

  logic [31:0] a_mag, b_mag, hi_next, lo_next, result_sel;
  logic [63:0] prod_raw, prod_fixed;
  logic        sign_diff, carry, last_iter;
  logic [5:0]  cnt_next;

  // The carry out of the shared adder is recovered by an unsigned wrap compare.
  assign carry    = b_mul_alu_adder_result_i < acc_hi;
  assign hi_next  = {carry, b_mul_alu_adder_result_i[31:1]};
  assign lo_next  = {b_mul_alu_adder_result_i[0], acc_lo[31:1]};
  assign cnt_next = cnt + 6'd1;

`ifdef IBEX_MUL_ITER_EARLY_EXIT_EN
  logic [31:0] bits_left;
  // Unconsumed multiplier bits sit in the low (32 - cnt_next) bits of the shifted acc_lo.
  assign bits_left = {1'b0, acc_lo[31:1]} & (32'hFFFF_FFFF >> cnt_next);
  assign last_iter = (cnt == 6'd31) || (bits_left == 32'd0);
  assign prod_raw  = {acc_hi, acc_lo} >> (6'd32 - cnt);
`else
  assign last_iter = cnt == 6'd31;
  assign prod_raw  = {acc_hi, acc_lo};
`endif

  ibex_mul_iter_signfix u_signfix (
    .operand_a  (a_q),
    .operand_b  (b_q),
    .operator   (op_q),
    .prod       (prod_raw),
    .neg        (neg_q),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .sign_diff  (sign_diff),
    .prod_fixed (prod_fixed)
  );

  assign result_sel = (op_q == MUL_OP_MUL) ? prod_fixed[31:0] : prod_fixed[63:32];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                 <= MUL_IDLE;
      op_q                  <= MUL_OP_MUL;
      a_q                   <= '0;
      b_q                   <= '0;
      a_mag_q               <= '0;
      acc_hi                <= '0;
      acc_lo                <= '0;
      neg_q                 <= 1'b0;
      cnt                   <= '0;
      mul_ready_o           <= 1'b1;
      mul_valid_o           <= 1'b0;
      mul_result_o          <= '0;
      adder_req_o           <= 1'b0;
      b_mul_alu_operand_a_o <= '0;
      b_mul_alu_operand_b_o <= '0;
    end else if (mul_kill_i && state != MUL_IDLE) begin
      state                 <= MUL_IDLE;
      mul_ready_o           <= 1'b1;
      mul_valid_o           <= 1'b0;
      adder_req_o           <= 1'b0;
      b_mul_alu_operand_a_o <= '0;
      b_mul_alu_operand_b_o <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (mul_valid_i && mul_ready_o && !mul_kill_i) begin
            op_q        <= mul_operator_i;
            a_q         <= mul_operand_a_i;
            b_q         <= mul_operand_b_i;
            mul_ready_o <= 1'b0;
            state       <= MUL_PREP;
          end
        end
        MUL_PREP: begin
          a_mag_q               <= a_mag;
          acc_hi                <= '0;
          acc_lo                <= b_mag;
          neg_q                 <= sign_diff;
          cnt                   <= '0;
          adder_req_o           <= 1'b1;
          b_mul_alu_operand_a_o <= '0;
          b_mul_alu_operand_b_o <= b_mag[0] ? a_mag : 32'd0;
          state                 <= MUL_ISSUE;
        end
        MUL_ISSUE: begin
          if (adder_gnt_i) begin
            adder_req_o           <= 1'b0;
            b_mul_alu_operand_a_o <= '0;
            b_mul_alu_operand_b_o <= '0;
            state                 <= MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          acc_hi <= hi_next;
          acc_lo <= lo_next;
          cnt    <= cnt_next;
          if (last_iter) begin
            state <= MUL_FINISH;
          end else begin
            // Next multiplier bit is acc_lo[1] before the shift lands.
            adder_req_o           <= 1'b1;
            b_mul_alu_operand_a_o <= hi_next;
            b_mul_alu_operand_b_o <= acc_lo[1] ? a_mag_q : 32'd0;
            state                 <= MUL_ISSUE;
          end
        end
        MUL_FINISH: begin
          mul_result_o <= result_sel;
          mul_valid_o  <= 1'b1;
          state        <= MUL_DONE;
        end
        MUL_DONE: begin
          if (mul_ready_i) begin
            mul_valid_o <= 1'b0;
            mul_ready_o <= 1'b1;
            state       <= MUL_IDLE;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_mul_iter.sv
// Randomized bench for ibex_mul_iter against a 64-bit arithmetic reference and a cycle-count model.
module tb_ibex_mul_iter;
  import ibex_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         mul_valid_i, mul_ready_o, mul_kill_i;
  mul_iter_op_e mul_operator_i;
  logic [31:0]  mul_operand_a_i, mul_operand_b_i;
  logic         adder_req_o, adder_gnt_i;
  logic [31:0]  opa, opb, adder_res;
  logic [31:0]  mul_result_o;
  logic         mul_valid_o, mul_ready_i;

  int vectors;
  int miscompares;

  ibex_mul_iter dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .mul_valid_i              (mul_valid_i),
    .mul_ready_o              (mul_ready_o),
    .mul_operator_i           (mul_operator_i),
    .mul_operand_a_i          (mul_operand_a_i),
    .mul_operand_b_i          (mul_operand_b_i),
    .mul_kill_i               (mul_kill_i),
    .adder_req_o              (adder_req_o),
    .adder_gnt_i              (adder_gnt_i),
    .b_mul_alu_operand_a_o    (opa),
    .b_mul_alu_operand_b_o    (opb),
    .b_mul_alu_adder_result_i (adder_res),
    .mul_result_o             (mul_result_o),
    .mul_valid_o              (mul_valid_o),
    .mul_ready_i              (mul_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared registered adder: sum appears the cycle after a grant.
  always @(posedge clk) begin
    if (adder_gnt_i) adder_res <= opa + opb;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input mul_iter_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = op_signed_a(op) ? {{32{a[31]}}, a} : {32'd0, a};
    bx = op_signed_b(op) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ax * bx;
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Number of adder iterations the multiply needs.
  function automatic int ref_iters(input mul_iter_op_e op, input logic [31:0] b);
    logic [31:0] bmag;
    int k;
    bmag = (op_signed_b(op) && b[31]) ? (32'd0 - b) : b;
    k = 32;
`ifdef IBEX_MUL_ITER_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < 32; i++) if (bmag[i]) k = i + 1;
`else
    if (bmag == 32'hFFFF_FFFF) k = 32;
`endif
    return k;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mul_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_issue", mul_ready_o, 1);
  endtask

  task automatic run_op(input mul_iter_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int deny_iter, input int deny_len, input bit rnd_gnt, input int ready_delay);
    int cyc, reqs, denials, grants, bad_ops, k;
    logic prev_stall;
    logic [31:0] pa, pb, res, prev_res, exp;
    wait_ready();
    exp = ref_mul(op, a, b);
    k   = ref_iters(op, b);
    prev_res = mul_result_o;
    mul_operator_i  = op;
    mul_operand_a_i = a;
    mul_operand_b_i = b;
    mul_valid_i     = 1'b1;
    @(posedge clk); #1;
    mul_valid_i = 1'b0;
    cyc = 1; reqs = 0; denials = 0; grants = 0; bad_ops = 0;
    prev_stall = 1'b0; pa = '0; pb = '0;
    while (!mul_valid_o && cyc < 400) begin
      if (prev_stall && (opa != pa || opb != pb)) bad_ops++;
      if (!adder_req_o && (opa != 0 || opb != 0)) bad_ops++;
      if (mul_result_o != prev_res) bad_ops++;
      prev_stall = 1'b0;
      adder_gnt_i = 1'b0;
      if (adder_req_o) begin
        reqs++;
        if ((grants == deny_iter && denials < deny_len) || (rnd_gnt && $urandom_range(0, 2) == 0)) begin
          denials++;
          prev_stall = 1'b1;
          pa = opa;
          pb = opb;
        end else begin
          adder_gnt_i = 1'b1;
          grants++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    adder_gnt_i = 1'b0;
    check("latency", cyc, 2 * k + 3 + denials);
    check("req_cycles", reqs, k + denials);
    check("operand_rules", bad_ops, 0);
    check("result", mul_result_o, exp);
    res = mul_result_o;
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      check("done_hold", {mul_valid_o, mul_ready_o, mul_result_o}, {1'b1, 1'b0, res});
    end
    mul_ready_i = 1'b1;
    @(posedge clk); #1;
    mul_ready_i = 1'b0;
    check("accept", {mul_valid_o, mul_ready_o, mul_result_o}, {1'b0, 1'b1, res});
  endtask

  // Accepts an op and runs it with constant grant until cycle n (sampled just after edge n).
  task automatic start_op(input mul_iter_op_e op, input logic [31:0] a, input logic [31:0] b, input int n);
    wait_ready();
    mul_operator_i  = op;
    mul_operand_a_i = a;
    mul_operand_b_i = b;
    mul_valid_i     = 1'b1;
    @(posedge clk); #1;
    mul_valid_i = 1'b0;
    for (int c = 1; c < n; c++) begin
      adder_gnt_i = adder_req_o;
      @(posedge clk); #1;
    end
    adder_gnt_i = adder_req_o;
  endtask

  initial begin
    int seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    mul_valid_i = 1'b0;
    mul_kill_i = 1'b0;
    mul_ready_i = 1'b0;
    adder_gnt_i = 1'b0;
    mul_operator_i = MUL_OP_MUL;
    mul_operand_a_i = '0;
    mul_operand_b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_outputs", {mul_valid_o, mul_ready_o, adder_req_o, mul_result_o, opa, opb},
          {1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0});

    run_op(MUL_OP_MUL,    32'd3,          32'd5,          -1, 0, 1'b0, 0);
    run_op(MUL_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  -1, 0, 1'b0, 0);
    run_op(MUL_OP_MULH,   32'h8000_0000,  32'h8000_0000,  -1, 0, 1'b0, 1);
    run_op(MUL_OP_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002,  -1, 0, 1'b0, 0);
    run_op(MUL_OP_MUL,    32'd7,          32'd1,          -1, 0, 1'b0, 0);
    run_op(MUL_OP_MUL,    32'd1,          32'h8000_0000,  -1, 0, 1'b0, 0);
    run_op(MUL_OP_MULH,   32'hFFFF_FFFD,  32'h0000_0005,  -1, 0, 1'b0, 0);
    run_op(MUL_OP_MUL,    32'h1234_5678,  32'h9ABC_DEF1,  10, 3, 1'b0, 5);

    for (int i = 0; i < 24; i++) begin
      run_op(mul_iter_op_e'($urandom_range(0, 3)), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom,
             -1, 0, 1'b1, $urandom_range(0, 3));
    end

    // Kill mid-operation.
    start_op(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'hFFFF_0001, 20);
    mul_kill_i = 1'b1;
    @(posedge clk); #1;
    mul_kill_i = 1'b0;
    adder_gnt_i = 1'b0;
    check("kill_idle", {mul_ready_o, mul_valid_o, adder_req_o}, 3'b100);
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (mul_valid_o || adder_req_o) seen++;
      @(posedge clk); #1;
    end
    check("kill_no_valid", seen, 0);

    // Reset mid-operation; the previous result must be cleared.
    start_op(MUL_OP_MUL, 32'hCAFE_0003, 32'h0BAD_F00D, 40);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    adder_gnt_i = 1'b0;
    check("rst_outputs", {mul_valid_o, mul_ready_o, adder_req_o, mul_result_o, opa, opb},
          {1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0});
    run_op(MUL_OP_MULHSU, 32'h8000_0001, 32'hFFFF_FFFF, -1, 0, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ibex_mul_iter.md
# ibex_mul_iter

Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU. It has no adder of its own: it time-shares the 32-bit registered adder in `ibex_branch_mul_alu`, driving its operands and consuming its result one cycle later. It sits between the ID/EX issue logic and that adder, and returns a 32-bit result to writeback through a valid/ready handshake.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `mul_valid_i` in 1: request valid.
- `mul_ready_o` out 1: block can accept a request (IDLE only).
- `mul_operator_i` in `mul_iter_op_e`: MUL, MULH, MULHSU or MULHU.
- `mul_operand_a_i` / `mul_operand_b_i` in 32: rs1 / rs2.
- `mul_kill_i` in 1: abort the current operation (flush).
- `adder_req_o` out 1: request for the shared adder this cycle.
- `adder_gnt_i` in 1: arbiter routed this block's operands to the adder this cycle.
- `b_mul_alu_operand_a_o` / `b_mul_alu_operand_b_o` out 32: adder operands.
- `b_mul_alu_adder_result_i` in 32: registered adder sum (valid the cycle after a grant).
- `mul_result_o` out 32: result.
- `mul_valid_o` out 1: result valid, held until accepted.
- `mul_ready_i` in 1: writeback accepts the result.

## Operation
- Handshake: a request is accepted when `mul_valid_i && mul_ready_o`, and the operands are latched then.
- Signedness:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH.
  - Unsigned for all other cases.
- FSM states: IDLE, PREP, ISSUE, WAIT, FINISH, DONE.
- IDLE → PREP on accept.
- PREP:
  - Latch magnitudes: `a_mag = |a|`, `b_mag = |b|`. 0x80000000 gives magnitude 0x80000000 with no overflow.
  - Latch `neg = sign_a ^ sign_b`.
  - Clear `acc_hi` and the carry bit, load `acc_lo = b_mag`, and set `cnt = 0`. Next state ISSUE.
- ISSUE:
  - Assert `adder_req_o`; drive operand a = `acc_hi` and operand b = `acc_lo[0] ? a_mag : 0`.
  - On `adder_gnt_i` go to WAIT; otherwise stay in ISSUE with the operands held stable.
- WAIT:
  - Sum `s = b_mul_alu_adder_result_i`; carry `c = (s < acc_hi)`, an unsigned compare done locally.
  - Shift right: `{acc_hi, acc_lo} <= {c, s, acc_lo[31:1]}` (the 64 bits to the right of `c`).
  - Increment `cnt`. Go to FINISH if `cnt == 31`, else back to ISSUE.
- FINISH:
  - If `neg`, replace the 64-bit product with its two's complement, computed locally (invert plus a local 64-bit incrementer, not the shared adder).
  - Select the low word for MUL, the high word otherwise. Go to DONE.
- DONE: `mul_valid_o = 1` with `mul_result_o` stable; on `mul_ready_i` go to IDLE.
- `adder_req_o` is asserted only in ISSUE. The operand outputs are 0 outside ISSUE.
- Kill: `mul_kill_i` in any state except IDLE → IDLE next cycle.
  - No `mul_valid_o` is produced, and a WAIT capture in that cycle is discarded.
  - Kill has priority over accept and over `mul_ready_i`.
- Reset:
  - Any state → IDLE.
  - `mul_valid_o = 0`, `mul_result_o = 0`, `adder_req_o = 0`, `mul_ready_o = 1` in the first cycle after reset. Internal registers are cleared.

## Timing
- Accept edge is cycle 0. With `adder_gnt_i` constantly high:
  - PREP in cycle 1.
  - 32 ISSUE/WAIT pairs in cycles 2–65.
  - FINISH in cycle 66.
  - `mul_valid_o` from cycle 67.
- Each cycle of grant denial adds one cycle.
- Back-to-back: `mul_ready_o` rises the cycle after DONE is accepted. There is no same-cycle accept while in DONE.
- `mul_result_o` changes only on entry to DONE or on reset.

## Configuration
- `IBEX_MUL_ITER_EARLY_EXIT_EN` defined:
  - In WAIT, if the remaining unconsumed multiplier bits (`acc_lo >> cnt_new` region) are all zero, go straight to FINISH.
  - FINISH applies the outstanding right shift of `31 - cnt` positions to `{c, acc_hi, acc_lo}` locally.
  - Latency becomes data-dependent, with a minimum of 5 cycles to valid for b_mag = 1.
- Undefined: fixed 32 iterations, no early-exit logic.

## Structure
- `ibex_pkg` gains `mul_iter_op_e` (MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU) and `mul_iter_state_e` for the six FSM states.
- One natural sub-module: `ibex_mul_iter_signfix`, the combinational magnitude/negate logic used in PREP and FINISH.

## Test plan
- MUL 3 × 5, gnt tied high → `mul_valid_o` at cycle 67, result 0x0000000F; `adder_req_o` high for exactly 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Grant withheld for 3 cycles on iteration 10, operands checked stable → valid at cycle 70, correct result.
- `mul_ready_i` low for 5 cycles in DONE → result and valid held; `mul_ready_o` stays 0 until the cycle after acceptance.
- `mul_kill_i` in cycle 20 → IDLE in cycle 21 with `mul_ready_o = 1`, no valid. `rst_ni` low in cycle 40 of a second op → all outputs at reset values the next cycle.
- With `IBEX_MUL_ITER_EARLY_EXIT_EN`: MUL 7 × 1 → valid at cycle 5, result 7. MUL 1 × 0x80000000 → full 32 iterations, result 0x80000000.
